// File: rtl/axis_frame_arbiter_pkg.sv
// Shared types and field-packing helpers for the frame arbiter.
// Beat layout, LSB first: data | keep (optional) | last | id | dest | user.
package axis_frame_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int keep_offset(input int data_w);
    return data_w;
  endfunction

  function automatic int last_offset(input int data_w, input bit keep_en, input int keep_w);
    return data_w + (keep_en ? keep_w : 0);
  endfunction

  function automatic int id_offset(input int data_w, input bit keep_en, input int keep_w);
    return last_offset(data_w, keep_en, keep_w) + 1;
  endfunction

  function automatic int dest_offset(input int data_w, input bit keep_en, input int keep_w,
                                     input int id_w);
    return id_offset(data_w, keep_en, keep_w) + id_w;
  endfunction

  function automatic int user_offset(input int data_w, input bit keep_en, input int keep_w,
                                     input int id_w, input int dest_w);
    return dest_offset(data_w, keep_en, keep_w, id_w) + dest_w;
  endfunction

  function automatic int beat_width(input int data_w, input bit keep_en, input int keep_w,
                                    input int id_w, input int dest_w, input int user_w);
    return user_offset(data_w, keep_en, keep_w, id_w, dest_w) + user_w;
  endfunction

endpackage

// File: rtl/axis_arb_skid_reg.sv
// Two-entry output register with skid slot; s_ready_o is a pure register output,
// so upstream ready never depends combinationally on m_ready_i.
module axis_arb_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic [WIDTH-1:0] out_data_q, skid_data_q;
  logic             out_valid_q, skid_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      skid_data_q  <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (m_ready_i || !out_valid_q) begin
      // Main register free: drain the skid first, otherwise take the input.
      if (skid_valid_q) begin
        out_data_q   <= skid_data_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= s_valid_i;
        if (s_valid_i) out_data_q <= s_data_i;
      end
    end else if (s_valid_i && !skid_valid_q) begin
      skid_data_q  <= s_data_i;
      skid_valid_q <= 1'b1;
    end
  end

  assign s_ready_o = !skid_valid_q;
  assign m_data_o  = out_data_q;
  assign m_valid_o = out_valid_q;

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-level round-robin merge of PORTS AXI-Stream sources; a grant is held
// until the winner's tlast beat is accepted, so frames never interleave.
module axis_frame_arbiter
  import axis_frame_arbiter_pkg::*;
#(
  parameter int PORTS       = 4,
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_WIDTH  = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0]       s_axis_tkeep,
  input  logic [PORTS-1:0]                  s_axis_tvalid,
  output logic [PORTS-1:0]                  s_axis_tready,
  input  logic [PORTS-1:0]                  s_axis_tlast,
  input  logic [PORTS*ID_WIDTH-1:0]         s_axis_tid,
  input  logic [PORTS*DEST_WIDTH-1:0]       s_axis_tdest,
  input  logic [PORTS*USER_WIDTH-1:0]       s_axis_tuser,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]             m_axis_tkeep,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [ID_WIDTH-1:0]               m_axis_tid,
  output logic [DEST_WIDTH-1:0]             m_axis_tdest,
  output logic [USER_WIDTH-1:0]             m_axis_tuser,
  output logic                              grant_valid,
  output logic [clog2_safe(PORTS)-1:0]      grant_index
);

  localparam int IDX_W       = clog2_safe(PORTS);
  localparam int KEEP_OFFSET = keep_offset(DATA_WIDTH);
  localparam int LAST_OFFSET = last_offset(DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH);
  localparam int ID_OFFSET   = id_offset(DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH);
  localparam int DEST_OFFSET = dest_offset(DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH, ID_WIDTH);
  localparam int USER_OFFSET = user_offset(DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH, ID_WIDTH,
                                           DEST_WIDTH);
  localparam int WIDTH       = beat_width(DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH, ID_WIDTH,
                                          DEST_WIDTH, USER_WIDTH);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_index_q, grant_index_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;

  logic [PORTS-1:0][WIDTH-1:0] beat_vec;
  logic [WIDTH-1:0]            sel_beat, m_beat;
  logic                        sel_valid, sel_last, skid_ready, skid_valid;
  logic [IDX_W-1:0]            pick;
  logic                        found;

  for (genvar i = 0; i < PORTS; i++) begin : g_port
    assign beat_vec[i][DATA_WIDTH-1:0] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    if (KEEP_ENABLE) begin : g_keep
      assign beat_vec[i][KEEP_OFFSET +: KEEP_WIDTH] = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
    end
    assign beat_vec[i][LAST_OFFSET]                = s_axis_tlast[i];
    assign beat_vec[i][ID_OFFSET +: ID_WIDTH]      = s_axis_tid[i*ID_WIDTH +: ID_WIDTH];
    assign beat_vec[i][DEST_OFFSET +: DEST_WIDTH]  = s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH];
    assign beat_vec[i][USER_OFFSET +: USER_WIDTH]  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
  end

  // Round-robin search: first valid port above last_grant, wrapping at PORTS.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      int idx;
      logic [IDX_W-1:0] cand;
      idx = int'(last_grant_q) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      cand = IDX_W'(idx);
      if (!found && s_axis_tvalid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_beat      = '0;
    s_axis_tready = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_index_q == IDX_W'(i)) begin
        sel_beat         = beat_vec[i];
        s_axis_tready[i] = (state_q == ST_GRANT) && skid_ready;
      end
    end
  end

  assign sel_valid  = s_axis_tvalid[grant_index_q];
  assign sel_last   = s_axis_tlast[grant_index_q];
  assign skid_valid = (state_q == ST_GRANT) && sel_valid;

  always_comb begin
    state_d       = state_q;
    grant_index_d = grant_index_q;
    last_grant_d  = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d       = ST_GRANT;
          grant_index_d = pick;
          last_grant_d  = pick;
        end
      end
      ST_GRANT: begin
        if (sel_valid && skid_ready && sel_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_index_q <= '0;
      last_grant_q  <= IDX_W'(PORTS - 1);
    end else begin
      state_q       <= state_d;
      grant_index_q <= grant_index_d;
      last_grant_q  <= last_grant_d;
    end
  end

  axis_arb_skid_reg #(.WIDTH(WIDTH)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data_i (sel_beat),
    .s_valid_i(skid_valid),
    .s_ready_o(skid_ready),
    .m_data_o (m_beat),
    .m_valid_o(m_axis_tvalid),
    .m_ready_i(m_axis_tready)
  );

  assign m_axis_tdata = m_beat[DATA_WIDTH-1:0];
  assign m_axis_tlast = m_beat[LAST_OFFSET];
  assign m_axis_tid   = m_beat[ID_OFFSET +: ID_WIDTH];
  assign m_axis_tdest = m_beat[DEST_OFFSET +: DEST_WIDTH];
  assign m_axis_tuser = m_beat[USER_OFFSET +: USER_WIDTH];
  if (KEEP_ENABLE) begin : g_mkeep
    assign m_axis_tkeep = m_beat[KEEP_OFFSET +: KEEP_WIDTH];
  end else begin : g_mkeep_ones
    assign m_axis_tkeep = '1;
  end

  assign grant_valid = (state_q == ST_GRANT);
  assign grant_index = grant_index_q;

endmodule

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
Frame-level round-robin arbiter that merges PORTS AXI-Stream sources onto one AXI-Stream master, typically the write side of the team's axis_fifo.
- Once a port wins, it keeps the grant until its tlast beat is accepted, so frames are never interleaved.
- The output is registered through a skid stage, so no upstream tready depends combinationally on m_axis_tready.

Parameters:
PORTS, 4, number of slave ports (2..16)
DATA_WIDTH, 8, tdata width per port
KEEP_ENABLE, DATA_WIDTH>8, carry tkeep
KEEP_WIDTH, DATA_WIDTH/8, tkeep width per port
ID_WIDTH, 8, tid width per port
DEST_WIDTH, 8, tdest width per port
USER_WIDTH, 1, tuser width per port

Ports:
clk  in  1  single clock; all logic is rising-edge
rst_n  in  1  asynchronous, active-low reset
s_axis_tdata  in  PORTS*DATA_WIDTH  packed; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tkeep  in  PORTS*KEEP_WIDTH  packed tkeep
s_axis_tvalid  in  PORTS  per-port valid
s_axis_tready  out  PORTS  per-port ready
s_axis_tlast  in  PORTS  per-port last
s_axis_tid  in  PORTS*ID_WIDTH  packed tid
s_axis_tdest  in  PORTS*DEST_WIDTH  packed tdest
s_axis_tuser  in  PORTS*USER_WIDTH  packed tuser
m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out (tready in)  single-port widths  merged stream
grant_valid  out  1  a frame is in progress
grant_index  out  $clog2(PORTS)  index of the granted port

Behaviour:
- Reset (rst_n low, takes effect asynchronously):
  - Outputs: m_axis_tvalid=0, s_axis_tready=0, grant_valid=0, grant_index=0.
  - Internal: skid register empty; round-robin pointer last_grant=PORTS-1, so port 0 has top priority after reset.
  - A frame in flight at reset is truncated; no tlast is emitted for it.
- FSM states:
  - IDLE: if any s_axis_tvalid is high, pick the first asserted port searching upward from last_grant+1 (modulo PORTS). At the next edge set grant_index to that port, grant_valid=1, last_grant=that port, and go to GRANT. If no valid is asserted, stay in IDLE.
  - GRANT: only s_axis_tready[grant_index] may be high; it equals !skid_full. Every other tready is 0.
    - A beat is accepted on tvalid & tready of the granted port.
    - When the accepted beat has tlast=1, go to IDLE at the same edge and clear grant_valid.
- Inter-frame gap: one cycle minimum between a tlast acceptance and the first beat of the next frame, including back-to-back frames from the same port.
- Fairness:
  - The pointer advances only on grant.
  - A continuously requesting port waits at most PORTS-1 frames.
  - A frame of any length holds the grant; there is no timeout.
- A requester dropping tvalid mid-frame keeps the grant; the arbiter waits.
- Output stage (two-entry register/skid):
  - Latency is one cycle from input acceptance to m_axis_tvalid.
  - Sustained throughput is 1 beat/cycle while m_axis_tready=1.
  - When m_axis_tready is low, the main register holds and one additional beat is captured in the skid register. s_axis_tready then drops the cycle after that capture.
  - Ordering is strictly preserved.
- tkeep: with KEEP_ENABLE=0, m_axis_tkeep is all ones and the input is ignored.
- Sideband (tid/tdest/tuser): passes through unmodified with its beat.
- grant_index is stable while grant_valid=1.

Decomposition:
- Shared package/header:
  - FSM state encoding (IDLE=1'b0, GRANT=1'b1).
  - Packed-field offset localparams (KEEP/LAST/ID/DEST/USER offsets and total WIDTH), computed the same way as the FIFO's field packing.
  - Function clog2_safe (returns 1 for PORTS=1..2).
- One sub-module, axis_arb_skid_reg: the WIDTH-bit two-entry output/skid buffer with s_ready/s_valid/m_ready/m_valid ports. The arbiter top holds the FSM, priority search and the input mux.

Test Plan:
1. Reset, then port 0 drives a 3-beat frame (data 0x10,0x11,0x12, last on 0x12), m_axis_tready=1 -> m_axis emits 0x10..0x12 with tlast on beat 3; grant_index=0; tvalid first seen 2 cycles after s_tvalid (grant + register).
2. All 4 ports continuously valid with 2-beat frames, tags = port number -> output frame order 0,1,2,3,0,1; never interleaved; 1 idle cycle between frames.
3. Port 2 granted; port 2 drops tvalid for 5 cycles mid-frame while port 1 is valid -> port 1 tready stays 0; frame 2 completes before any port 1 beat.
4. m_axis_tready held 0 for 10 cycles during a 6-beat frame -> exactly 2 beats buffered, s_axis_tready[grant] low after the skid fills, no beat lost or duplicated after release.
5. rst_n asserted mid-frame (beat 2 of 4, port 3) -> m_axis_tvalid and all tready fall without waiting for a clock edge. After release, port 0 wins over port 3 when both are valid.
6. DATA_WIDTH=16, KEEP_ENABLE=1, tkeep=2'b01 on the last beat, tid=0xA5, tdest=0x3C, tuser=1 -> identical values on m_axis; with KEEP_ENABLE=0, m_axis_tkeep=2'b11.
